// File: rtl/crc_frame_seq_pkg.sv
// Shared types and sizing helpers for the CRC frame sequencer.
// Defining CRC_AUGMENT_EN appends CRC_W zero flush bits after the payload.
package crc_seq_pkg;

  localparam int DATA_W_DEF = 48;
  localparam int CRC_W_DEF  = 16;

`ifdef CRC_AUGMENT_EN
  localparam bit AUGMENT = 1'b1;
`else
  localparam bit AUGMENT = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, WAIT, OUT} state_t;

  // Number of serial beats driven into the engine per frame.
  function automatic int nshift_f(input int data_w, input int crc_w);
    return data_w + (AUGMENT ? crc_w : 0);
  endfunction

  function automatic int cnt_w_f(input int data_w, input int crc_w);
    return $clog2(data_w + crc_w + 1);
  endfunction

endpackage

// File: rtl/crc_frame_seq_if.sv
// Payload-in / frame-out valid-ready handshakes of the CRC frame sequencer.
interface crc_frame_seq_if #(
  parameter int DATA_W = 48,
  parameter int CRC_W  = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W+CRC_W-1:0] out_frame;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_frame);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_frame);
endinterface

// File: rtl/crc_frame_seq_piso.sv
// Loadable MSB-first left-shift register with beat counter and last-beat flag.
module crc_seq_piso #(
  parameter int WIDTH = 48,
  parameter int CW    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  output logic             msb,
  output logic [CW-1:0]    cnt,
  output logic             last
);

  logic [WIDTH-1:0] sr;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= load_data;
      cnt <= '0;
    end else if (shift) begin
      sr  <= {sr[WIDTH-2:0], 1'b0};
      cnt <= cnt + CW'(1);
    end else if (clear) begin
      cnt <= '0;
    end
  end

  assign msb  = sr[WIDTH-1];
  assign last = (cnt == CW'(WIDTH));

endmodule

// File: rtl/crc_frame_seq.sv
// CRC transmit-path sequencer: serialises a payload into the CRC engine and
// emits {payload, crc}. CRC_AUGMENT_EN adds CRC_W zero flush beats.
module crc_frame_seq
  import crc_seq_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CRC_W   = CRC_W_DEF,
  parameter int CRC_LAT = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  crc_frame_seq_if.slave                     bus,
  output logic                               crc_clr,
  output logic                               crc_en,
  output logic                               crc_bit,
  input  logic [CRC_W-1:0]                   crc_val,
  output logic                               busy,
  output logic [cnt_w_f(DATA_W, CRC_W)-1:0]  bit_cnt
);

  localparam int NSHIFT = nshift_f(DATA_W, CRC_W);
  localparam int CW     = cnt_w_f(DATA_W, CRC_W);
  localparam int WW     = $clog2(CRC_LAT + 1);

  state_t            state, next_state;
  logic [DATA_W-1:0] payload;
  logic [WW-1:0]     wait_cnt;
  logic [NSHIFT-1:0] sr_load;
  logic              sr_msb, sr_last;
  logic              accept, handshake, wait_done;

  assign accept       = bus.in_valid && (state == IDLE);
  assign handshake    = bus.out_ready && (state == OUT);
  assign wait_done    = (state == WAIT) && (wait_cnt == WW'(1));
  assign bus.in_ready = (state == IDLE);
  assign busy         = (state != IDLE);

  // Payload sits in the MSBs; any flush beats below it shift out as zeros.
  always_comb begin
    sr_load = '0;
    sr_load[NSHIFT-1 -: DATA_W] = bus.in_data;
  end

  crc_seq_piso #(.WIDTH(NSHIFT), .CW(CW)) u_piso (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .shift     (next_state == SHIFT),
    .clear     (handshake),
    .load_data (sr_load),
    .msb       (sr_msb),
    .cnt       (bit_cnt),
    .last      (sr_last)
  );

  // NOTE: next_state gets its default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  next_state = CLR;
      CLR:                        next_state = SHIFT;
      SHIFT:   if (sr_last)       next_state = WAIT;
      WAIT:    if (wait_done)     next_state = OUT;
      OUT:     if (bus.out_ready) next_state = IDLE;
      default:                    next_state = IDLE;
    endcase
  end

  // Engine and frame outputs are registered from next_state so they align with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      crc_clr       <= 1'b0;
      crc_en        <= 1'b0;
      crc_bit       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_frame <= '0;
      payload       <= '0;
      wait_cnt      <= '0;
    end else begin
      state         <= next_state;
      crc_clr       <= (next_state == CLR);
      crc_en        <= (next_state == SHIFT);
      crc_bit       <= (next_state == SHIFT) && sr_msb;
      bus.out_valid <= (next_state == OUT);
      if (accept)
        payload <= bus.in_data;
      if (state == SHIFT && sr_last)
        wait_cnt <= WW'(CRC_LAT);
      else if (state == WAIT)
        wait_cnt <= wait_cnt - WW'(1);
      if (wait_done)
        bus.out_frame <= {payload, crc_val};
    end
  end

endmodule

// File: tb/tb_crc_frame_seq.sv
// Self-checking bench for crc_frame_seq with a bit-serial CRC-16 stub engine.
`timescale 1ns/1ps
module tb_crc_frame_seq;

  localparam int DW   = 48;
  localparam int CRCW = 16;
  localparam int LAT  = 1;
`ifdef CRC_AUGMENT_EN
  localparam int NS = DW + CRCW;
`else
  localparam int NS = DW;
`endif
  localparam int CW = $clog2(DW + CRCW + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            crc_clr, crc_en, crc_bit, busy;
  logic [CRCW-1:0] crc_val;
  logic [CW-1:0]   bit_cnt;

  int compared   = 0;
  int mismatched = 0;

  crc_frame_seq_if #(.DATA_W(DW), .CRC_W(CRCW)) bus ();

  crc_frame_seq #(.DATA_W(DW), .CRC_W(CRCW), .CRC_LAT(LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .crc_clr (crc_clr),
    .crc_en  (crc_en),
    .crc_bit (crc_bit),
    .crc_val (crc_val),
    .busy    (busy),
    .bit_cnt (bit_cnt)
  );

  always #5 clk = ~clk;

  // Stub engine: CRC-16/CCITT, one bit per crc_en beat, result registered.
  logic [15:0] eng_crc = '0;
  logic        fixed_mode = 1'b1;
  bit          eng_bits[$];
  int          cyc = 0, clr_cnt = 0, beat_cnt = 0, hs_cnt = 0, last_hs_cyc = 0;

  assign crc_val = fixed_mode ? 16'hBEEF : eng_crc;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (crc_clr) begin
      eng_crc <= 16'hFFFF;
      eng_bits.delete();
      clr_cnt <= clr_cnt + 1;
    end else if (crc_en) begin
      eng_crc <= {eng_crc[14:0], 1'b0} ^ ((eng_crc[15] ^ crc_bit) ? 16'h1021 : 16'h0000);
      eng_bits.push_back(crc_bit);
      beat_cnt <= beat_cnt + 1;
    end
    if (bus.out_valid && bus.out_ready) begin
      hs_cnt      <= hs_cnt + 1;
      last_hs_cyc <= cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: CRC over the payload MSB-first followed by NS-DW zero bits.
  function automatic logic [15:0] ref_crc(input logic [DW-1:0] p);
    logic [15:0] c;
    logic        b;
    c = 16'hFFFF;
    for (int i = 0; i < NS; i++) begin
      b = (i < DW) ? p[DW-1-i] : 1'b0;
      c = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // mode: 0 = in_valid low mid-frame, 1 = random in_valid/in_data/out_ready noise, 2 = in_valid held high.
  task automatic run_frame(input logic [DW-1:0] p, input bit use_fixed, input int hold,
                           input bit b2b, input int mode);
    int                  k, lat, waited, clr0, beat0, hs0;
    bit                  bad;
    logic [CRCW-1:0]     exp_crc;
    logic [NS-1:0]       got, expb;
    fixed_mode = use_fixed;
    exp_crc    = use_fixed ? 16'hBEEF : ref_crc(p);
    waited = 0;
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_before_accept", bus.in_ready, 1);
    if (b2b) check("b2b_accept_edge", cyc + 1, last_hs_cyc + 1);
    clr0 = clr_cnt; beat0 = beat_cnt; hs0 = hs_cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = p;
    @(negedge clk);
    k = cyc;
    check("clr_pulse_k+1", crc_clr, 1);
    check("in_ready_after_accept", bus.in_ready, 0);
    lat = 1;
    while (!bus.out_valid && lat < 400) begin
      if (mode == 1) begin
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.in_data   = DW'({$urandom, $urandom});
        bus.out_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.in_valid = (mode == 2);
      end
      @(negedge clk);
      lat = cyc + 1 - k;
    end
    bus.out_ready = 1'b0;
    check("out_valid_cycle", lat, 2 + NS + LAT);
    check("clr_pulses", clr_cnt - clr0, 1);
    check("crc_en_beats", beat_cnt - beat0, NS);
    check("bit_cnt_at_out", bit_cnt, NS);
    for (int i = 0; i < NS; i++) begin
      got[NS-1-i]  = (i < eng_bits.size()) ? eng_bits[i] : 1'bx;
      expb[NS-1-i] = (i < DW) ? p[DW-1-i] : 1'b0;
    end
    check("crc_bit_stream", 64'(got), 64'(expb));
    check("out_frame", bus.out_frame, {p, exp_crc});
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 2);
      bus.in_data  = (mode == 1) ? DW'({$urandom, $urandom}) : p;
      @(negedge clk);
      if (bus.out_frame !== {p, exp_crc} || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
        bad = 1'b1;
    end
    check("hold_stable", bad, 0);
    check("no_early_handshake", hs_cnt - hs0, 0);
    bus.in_valid  = (mode == 2);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("handshakes", hs_cnt - hs0, 1);
    check("out_valid_cleared", bus.out_valid, 0);
    check("bit_cnt_cleared", bit_cnt, 0);
    check("in_ready_after_out", bus.in_ready, 1);
  endtask

  initial begin
    int          waited, ov_seen;
    logic [7:0]  first8;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_frame", bus.out_frame, 0);
    check("rst_crc_ctrl", {crc_clr, crc_en, crc_bit}, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame with fixed engine result.
    run_frame(48'h030102030000, 1'b1, 0, 1'b0, 0);
    for (int i = 0; i < 8; i++) first8[7-i] = (i < eng_bits.size()) ? eng_bits[i] : 1'bx;
    check("first8_bits", first8, 8'b0000_0011);

    // Backpressure for 20 cycles.
    run_frame(DW'({$urandom, $urandom}), 1'b0, 20, 1'b0, 0);

    // Back-to-back with in_valid held high.
    run_frame(48'hFFFFFFFFFFFF, 1'b0, 0, 1'b0, 2);
    run_frame(48'h000000000001, 1'b0, 0, 1'b1, 2);

    // Reset asserted mid-SHIFT at bit_cnt = 20.
    fixed_mode   = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = DW'({$urandom, $urandom});
    @(negedge clk);
    bus.in_valid = 1'b0;
    waited = 0;
    while (bit_cnt != CW'(20) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("reached_bit_cnt_20", bit_cnt, 20);
    rst_n = 1'b0;
    #1;
    check("midrst_crc_ctrl", {crc_clr, crc_en, crc_bit}, 0);
    check("midrst_bit_cnt", bit_cnt, 0);
    check("midrst_out_frame", bus.out_frame, 0);
    check("midrst_ready_busy", {bus.in_ready, busy, bus.out_valid}, 3'b100);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    repeat (2 * (NS + LAT + 3)) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen++;
    end
    check("no_out_valid_after_rst", ov_seen, 0);
    run_frame(DW'({$urandom, $urandom}), 1'b0, 2, 1'b0, 0);

    // Ignored in_valid/in_data/out_ready noise outside IDLE/OUT windows.
    for (int n = 0; n < 4; n++)
      run_frame(DW'({$urandom, $urandom}), 1'b0, int'($urandom_range(0, 5)), 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/crc_frame_seq.md
Name: crc_frame_seq

Overview:
Sequencer for the CRC transmit path. It accepts one DATA_W-bit payload per frame and serialises it MSB-first into the serial CRC engine, driving clear, enable and bit. It then waits for the engine's registered result, and presents the payload with the CRC appended as one parallel frame to the downstream interleaver stage. Valid/ready handshakes are used on both sides.

Parameters:
DATA_W, 48, payload width in bits (>=8).
CRC_W, 16, CRC width in bits; also the width of crc_val.
CRC_LAT, 1, cycles from the last crc_en beat until crc_val is stable (>=1).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  payload offered.
in_ready  out  1  sequencer can accept a payload.
in_data  in  DATA_W  payload.
crc_clr  out  1  one-cycle pulse that clears the CRC engine.
crc_en  out  1  crc_bit is valid this cycle.
crc_bit  out  1  serial bit to the engine.
crc_val  in  CRC_W  CRC result from the engine.
out_valid  out  1  frame available.
out_ready  in  1  downstream accepts the frame.
out_frame  out  DATA_W+CRC_W  {payload, crc}, with the payload in the MSBs.
busy  out  1  high in any state except IDLE.
bit_cnt  out  CW  bits shifted so far; CW = $clog2(DATA_W+CRC_W+1).

Behaviour:
- Reset values: state=IDLE, in_ready=1, crc_clr=0, crc_en=0, crc_bit=0, out_valid=0, out_frame=0, busy=0, bit_cnt=0, shift register=0.
- All outputs are registered except in_ready and busy, which decode the state.
- IDLE: in_ready=1. On in_valid&&in_ready at edge k:
  - latch in_data into the shift register and the payload hold register;
  - go to CLR.
- CLR: lasts exactly 1 cycle (the cycle after edge k). crc_clr=1, crc_en=0. Go to SHIFT.
- SHIFT: lasts NSHIFT cycles (NSHIFT = DATA_W by default).
  - Each cycle: crc_en=1, crc_bit=shift MSB.
  - Shift left with zero fill; bit_cnt increments.
  - After the last beat, go to WAIT with a wait counter set to CRC_LAT.
- WAIT: crc_en=0, crc_bit=0. Count down CRC_LAT cycles. In the final WAIT cycle:
  - sample crc_val;
  - load out_frame = {payload, crc_val};
  - go to OUT.
- OUT: out_valid=1. out_frame holds stable while out_ready=0.
  - On out_ready: clear out_valid and bit_cnt, return to IDLE.
  - in_ready stays 0 during OUT, so there is no overlap. The next frame can be accepted on the cycle after the handshake.
- Latency:
  - out_valid first rises in cycle k+2+NSHIFT+CRC_LAT relative to accept edge k.
  - Minimum frame period is NSHIFT+CRC_LAT+3 cycles.
- in_valid is ignored outside IDLE, and the payload is never re-sampled mid-frame.
- in_valid and out_ready toggling in the same cycle has no interaction, because the states are exclusive.
- Reset asserted mid-frame, in any state:
  - all outputs return to reset values immediately (asynchronous);
  - the partial frame is discarded;
  - no out_valid is produced for it.
- Wrap-around: bit_cnt never exceeds NSHIFT, and is cleared on return to IDLE.

Optional Feature:
Macro CRC_AUGMENT_EN.
- Defined: NSHIFT = DATA_W+CRC_W. After the payload, CRC_W zero bits are shifted with crc_en=1. This flushes augmented-message engines.
- Undefined: NSHIFT = DATA_W, with no flush bits.
- out_frame format and the handshakes are identical in both builds.

Decomposition:
- Package crc_seq_pkg holds:
  - state enum {IDLE, CLR, SHIFT, WAIT, OUT};
  - localparam functions for NSHIFT and CW;
  - default constants DATA_W=48, CRC_W=16.
- One natural sub-module: crc_seq_piso, the loadable left-shift register with its bit counter and a last-beat flag.
- The FSM, wait counter and output registers stay in crc_frame_seq.

Test Plan:
1. Basic frame. Reset, then in_data=48'h030102030000 accepted at edge k, with a stub engine returning crc_val=16'hBEEF.
   Required: crc_clr high for 1 cycle at k+1; crc_bit first 8 beats = 0,0,0,0,0,0,1,1; exactly 48 crc_en beats; out_valid at k+51 (CRC_LAT=1); out_frame=64'h030102030000BEEF.
2. Backpressure. Hold out_ready=0 for 20 cycles after out_valid.
   Required: out_frame stable; in_ready=0 throughout; exactly one handshake when out_ready rises.
3. Back-to-back. Keep in_valid=1 with payloads 48'hFFFFFFFFFFFF then 48'h000000000001, and out_ready=1.
   Required: second accept one cycle after the first out handshake; second crc_bit stream is 47 zeros then a single 1.
4. Reset mid-SHIFT. Assert rst_n=0 at bit_cnt=20.
   Required: all outputs at reset values within the same cycle; no out_valid; a later frame completes correctly.
5. CRC_AUGMENT_EN build.
   Required: 64 crc_en beats; last 16 crc_bit=0; out_valid at k+67.
6. Ignored input. Pulse in_valid during SHIFT and OUT.
   Required: no payload change; no extra crc_clr pulse.
